// File: rtl/serial_mac_sequencer_pkg.sv
// Shared types and default sizing for the serial multiplier MAC sequencer.
// The product width follows the operand width: two full signed operands.
package serial_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 9;
    localparam int DEF_PROD_W  = 2 * DEF_WIDTH;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/serial_mac_sequencer_acc.sv
// Wide signed accumulator with product counter and sticky overflow flag.
// Arithmetic wraps; the overflow flag records that a wrap occurred.
module mac_acc_unit
    import serial_mac_sequencer_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     add_en,
    input  logic                     clr,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  acc,
    output logic        [CNT_W-1:0]  count,
    output logic                     ovf
);

    function automatic logic signed [ACC_W-1:0] sign_extend(input logic signed [PROD_W-1:0] p);
        return ACC_W'(p);
    endfunction

    // Two same-signed addends producing a sum of the other sign means the add wrapped.
    function automatic logic add_overflow(input logic signed [ACC_W-1:0] a,
                                          input logic signed [ACC_W-1:0] b,
                                          input logic signed [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum;

    always_comb begin
        addend = sign_extend(prod);
        sum    = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (add_en) begin
            acc   <= sum;
            count <= count + CNT_W'(1);
            if (add_overflow(acc, addend, sum))
                ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/serial_mac_sequencer.sv
// Feeds operand pairs to a serial signed multiplier one at a time and
// accumulates the products into a dot product handed downstream on last.
module serial_mac_sequencer
    import serial_mac_sequencer_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   in_a,
    input  logic signed [WIDTH-1:0]   in_b,
    input  logic                      in_last,
    output logic                      mul_en,
    output logic signed [WIDTH-1:0]   mul_a,
    output logic signed [WIDTH-1:0]   mul_b,
    input  logic                      mul_valid,
    input  logic signed [2*WIDTH-1:0] mul_s,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [ACC_W-1:0]   out_acc,
    output logic        [CNT_W-1:0]   out_count,
    output logic                      out_ovf,
    output logic                      err_timeout
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int TO_W   = $clog2(TIMEOUT) + 1;

    state_t                    state_q;
    state_t                    state_d;
    logic                      last_q;
    logic                      mul_valid_q;
    logic [TO_W-1:0]           tmo_cnt;
    logic                      capture;
    logic                      timed_out;
    logic                      acc_clr;
    logic signed [PROD_W-1:0]  add_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mul_en    = 1'b0;
        out_valid = 1'b0;
        capture   = 1'b0;
        timed_out = 1'b0;
        acc_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = ISSUE;
            end
            ISSUE: begin
                mul_en  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Only a fresh rising edge counts, so a level left high from an earlier op is ignored.
                if (mul_valid && !mul_valid_q)
                    capture = 1'b1;
                else if (tmo_cnt == TO_W'(TIMEOUT - 1))
                    timed_out = 1'b1;
                if (capture || timed_out)
                    state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a       <= '0;
            mul_b       <= '0;
            last_q      <= 1'b0;
            mul_valid_q <= 1'b0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            mul_valid_q <= mul_valid;
            if (state_q == IDLE && in_valid) begin
                mul_a  <= in_a;
                mul_b  <= in_b;
                last_q <= in_last;
            end
            if (state_q == ISSUE)
                tmo_cnt <= '0;
            else if (state_q == WAIT)
                tmo_cnt <= tmo_cnt + TO_W'(1);
            if (timed_out)
                err_timeout <= 1'b1;
        end
    end

    // A timed-out operation still advances the count but contributes nothing to the sum.
    always_comb begin
        add_val = mul_s;
        if (timed_out)
            add_val = '0;
    end

    mac_acc_unit #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .add_en (capture || timed_out),
        .clr    (acc_clr),
        .prod   (add_val),
        .acc    (out_acc),
        .count  (out_count),
        .ovf    (out_ovf)
    );

endmodule

// File: tb/tb_serial_mac_sequencer.sv
// Directed bench for serial_mac_sequencer with a behavioural serial multiplier model.
module tb_serial_mac_sequencer;

    localparam int WIDTH   = 9;
    localparam int ACC_W   = 18;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a = '0;
    logic [WIDTH-1:0]     in_b = '0;
    logic                 in_last = 1'b0;
    logic                 mul_en;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_valid = 1'b0;
    logic [2*WIDTH-1:0]   mul_s = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [ACC_W-1:0]     out_acc;
    logic [CNT_W-1:0]     out_count;
    logic                 out_ovf;
    logic                 err_timeout;

    int checks = 0;
    int errors = 0;

    int                 lat = 20;
    bit                 mul_dead = 1'b0;
    int                 mcnt = 0;
    logic [2*WIDTH-1:0] pend = '0;
    int                 en_pulses = 0;
    int                 en_run = 0;
    int                 en_max = 0;
    int                 p0;
    int                 n;

    always #5 clk = ~clk;

    serial_mac_sequencer #(
        .WIDTH   (WIDTH),
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_last     (in_last),
        .mul_en      (mul_en),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_valid   (mul_valid),
        .mul_s       (mul_s),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_count   (out_count),
        .out_ovf     (out_ovf),
        .err_timeout (err_timeout)
    );

    // Multiplier model: result appears lat cycles after the start pulse and stays high.
    always @(posedge clk) begin
        if (mul_en) begin
            mcnt      <= lat;
            mul_valid <= 1'b0;
            pend      <= 18'($signed(mul_a)) * 18'($signed(mul_b));
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !mul_dead) begin
                mul_valid <= 1'b1;
                mul_s     <= pend;
            end
        end
    end

    always @(posedge clk) begin
        if (mul_en) begin
            en_pulses <= en_pulses + 1;
            en_run    <= en_run + 1;
            if (en_run + 1 > en_max)
                en_max <= en_run + 1;
        end else begin
            en_run <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] av(input int v);
        logic [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return 64'(t);
    endfunction

    task automatic wait_idle(input string tag);
        int k = 0;
        while (in_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(in_ready), 64'd1);
    endtask

    task automatic send(input int a, input int b, input bit last);
        wait_idle("send_ready");
        in_a     = a[WIDTH-1:0];
        in_b     = b[WIDTH-1:0];
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (out_valid !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_acc_clr"},   64'(out_acc),   64'd0);
        chk({tag, "_cnt_clr"},   64'(out_count), 64'd0);
        chk({tag, "_ovf_clr"},   64'(out_ovf),   64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),    64'd1);
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_mul_en",    64'(mul_en),      64'd0);
        chk("rst_out_acc",   64'(out_acc),     64'd0);
        chk("rst_out_count", 64'(out_count),   64'd0);
        chk("rst_err",       64'(err_timeout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-pair dot product; out_ready pulsed outside DONE must be harmless.
        send(3, 4, 1'b0);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        send(-5, 6, 1'b1);
        wait_done("t1_done");
        chk("t1_acc",   out_acc,            av(-18));
        chk("t1_count", 64'(out_count),     64'd2);
        chk("t1_ovf",   64'(out_ovf),       64'd0);
        chk("t1_err",   64'(err_timeout),   64'd0);
        accept("t1_acc");

        // Single-pair dot product at the most negative operand.
        p0 = en_pulses;
        send(-256, -256, 1'b1);
        wait_done("t2_done");
        chk("t2_acc",       out_acc,             av(65536));
        chk("t2_count",     64'(out_count),      64'd1);
        chk("t2_en_pulses", 64'(en_pulses - p0), 64'd1);
        chk("t2_en_width",  64'(en_max),         64'd1);
        chk("t2_mul_a_hold", 64'(mul_a),         64'h100);
        accept("t2_acc");

        // Wrapping accumulation with the 18-bit accumulator.
        send(255, 255, 1'b0);
        send(255, 255, 1'b0);
        send(255, 255, 1'b1);
        wait_done("t3_done");
        chk("t3_acc",   out_acc,        av(-67069));
        chk("t3_count", 64'(out_count), 64'd3);
        chk("t3_ovf",   64'(out_ovf),   64'd1);
        accept("t3_acc");

        // Stall in DONE while upstream keeps offering a pair.
        p0 = en_pulses;
        send(10, -10, 1'b1);
        wait_done("t4_done");
        in_a     = 9'd1;
        in_b     = 9'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_acc",   out_acc,        av(-100));
            chk("t4_hold_ready", 64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        chk("t4_ovf_cleared", 64'(out_ovf),          64'd0);
        chk("t4_no_issue",    64'(en_pulses - p0),   64'd1);
        accept("t4_acc");

        // Timeout: a live product, then a last pair the multiplier never answers.
        send(7, 8, 1'b0);
        wait_idle("t5_idle");
        mul_dead = 1'b1;
        chk("t5_err_pre", 64'(err_timeout), 64'd0);
        send(1, 1, 1'b1);
        repeat (TIMEOUT) @(negedge clk);
        chk("t5_wait_valid", 64'(out_valid),   64'd0);
        chk("t5_wait_err",   64'(err_timeout), 64'd0);
        @(negedge clk);
        chk("t5_tmo_valid", 64'(out_valid),   64'd1);
        chk("t5_tmo_err",   64'(err_timeout), 64'd1);
        chk("t5_acc",       out_acc,          av(56));
        chk("t5_count",     64'(out_count),   64'd2);
        accept("t5_acc");
        chk("t5_err_sticky", 64'(err_timeout), 64'd1);
        mul_dead = 1'b0;

        // Asynchronous reset in the middle of WAIT.
        send(5, 5, 1'b0);
        wait_idle("t6_idle");
        send(9, 9, 1'b0);
        repeat (5) @(negedge clk);
        chk("t6_pre_acc",   out_acc,        av(25));
        chk("t6_pre_count", 64'(out_count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_ready", 64'(in_ready),    64'd1);
        chk("t6_rst_mul_en",   64'(mul_en),      64'd0);
        chk("t6_rst_valid",    64'(out_valid),   64'd0);
        chk("t6_rst_acc",      64'(out_acc),     64'd0);
        chk("t6_rst_count",    64'(out_count),   64'd0);
        chk("t6_rst_err",      64'(err_timeout), 64'd0);
        chk("t6_rst_mul_a",    64'(mul_a),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("t6_stale_ignored", 64'(out_count), 64'd0);
        send(2, -3, 1'b1);
        wait_done("t6_done");
        chk("t6_acc",   out_acc,        av(-6));
        chk("t6_count", 64'(out_count), 64'd1);
        chk("t6_ovf",   64'(out_ovf),   64'd0);
        accept("t6_acc");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
